// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command-protocol initiator.
// Opcodes, cmd_op encodings, frame kinds and FSM state codes.
package spi_cmd_pkg;

  localparam logic [7:0] OPC_SEND  = 8'h66;
  localparam logic [7:0] OPC_FETCH = 8'h77;
  localparam logic [7:0] OPC_CFG   = 8'h11;

  localparam logic [1:0] OP_SEND = 2'b01;
  localparam logic [1:0] OP_CFG  = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [1:0] {
    K_SEND,
    K_CFG,
    K_FETCH
  } kind_t;

endpackage

// File: rtl/spi_master_byte.sv
// SPI mode-0 byte shifter: one load shifts 8 bits MSB first.
// byte_done strobes in the cycle of the 8th falling SCLK edge.
module spi_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic          active;
  logic          tick;

  assign tick = active && (div == DW'(CLK_DIV - 1));
  assign byte_done = tick && sclk && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_byte <= '0;
    end else if (load) begin
      div     <= '0;
      bit_cnt <= '0;
      tx_sh   <= tx_byte;
      active  <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= tx_byte[7];
    end else if (active) begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        sclk <= !sclk;
        if (!sclk) begin
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end else begin
            tx_sh <= {tx_sh[6:0], 1'b0};
            mosi  <= tx_sh[6];
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI command initiator: send, config and irq-driven fetch.
// Frame FSM, gap timing, arbitration and irq synchronizer live here.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  input  logic        irq_n,
  input  logic        cmd_start,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_len,
  output logic        busy,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  input  logic        rx_en,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_first,
  output logic        done,
  output logic        cmd_err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [2:0]    state;
  kind_t         kind;
  logic [1:0]    hdr_idx;
  logic [1:0]    hdr_n;
  logic [15:0]   cnt;
  logic [15:0]   len;
  logic [GW-1:0] gap_cnt;
  logic          irq_meta;
  logic          irq_s;
  logic          rx_armed;
  logic          in_hdr;
  logic          first;
  logic          load;
  logic          byte_done;
  logic          cmd_ok;
  logic          fetch_req;
  logic [7:0]    hdr_byte;
  logic [7:0]    tx_byte;
  logic [7:0]    rx_byte;

  assign hdr_n  = (kind == K_CFG) ? 2'd3 : 2'd2;
  assign in_hdr = hdr_idx < hdr_n;
  assign first  = hdr_idx == 2'd0;
  assign load   = state == ST_LOAD;
  assign src_rd = load && !in_hdr && kind != K_FETCH;
  assign done   = state == ST_FINISH;
  assign busy   = !(state == ST_IDLE || done);

  assign cmd_ok =
    (cmd_op == OP_SEND && cmd_len != '0 && cmd_len <= 16'd255) ||
    (cmd_op == OP_CFG && cmd_len != '0);
  assign fetch_req = rx_en && !irq_s && rx_armed;

  always_comb begin
    hdr_byte = DUMMY_BYTE;
    unique case (kind)
      K_SEND:  hdr_byte = first ? OPC_SEND : len[7:0];
      K_CFG:   hdr_byte = first ? OPC_CFG :
                          (hdr_idx == 2'd1) ? len[15:8] : len[7:0];
      default: hdr_byte = first ? OPC_FETCH : DUMMY_BYTE;
    endcase
  end

  always_comb begin
    tx_byte = hdr_byte;
    if (!in_hdr) tx_byte = (kind == K_FETCH) ? DUMMY_BYTE : src_data;
  end

  spi_master_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_byte (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .tx_byte  (tx_byte),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_byte  (rx_byte),
    .byte_done(byte_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      kind     <= K_SEND;
      hdr_idx  <= '0;
      cnt      <= '0;
      len      <= '0;
      gap_cnt  <= '0;
      irq_meta <= 1'b1;
      irq_s    <= 1'b1;
      rx_armed <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      irq_meta <= irq_n;
      irq_s    <= irq_meta;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      cmd_err  <= 1'b0;
      // a fetch clears this; only a high irq_s may re-arm it
      if (irq_s) rx_armed <= 1'b1;
      unique case (state)
        ST_IDLE, ST_FINISH: begin
          state   <= ST_IDLE;
          hdr_idx <= '0;
          cnt     <= '0;
          if (cmd_start) begin
            if (cmd_ok) begin
              kind  <= (cmd_op == OP_SEND) ? K_SEND : K_CFG;
              len   <= cmd_len;
              state <= ST_LOAD;
            end else begin
              cmd_err <= 1'b1;
            end
          end else if (fetch_req) begin
            kind     <= K_FETCH;
            len      <= '0;
            rx_armed <= 1'b0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_SHIFT;
        ST_SHIFT: begin
          if (byte_done) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
            if (in_hdr) hdr_idx <= hdr_idx + 2'd1;
            else        cnt <= cnt + 16'd1;
            if (kind == K_FETCH && !first) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_byte;
              if (hdr_idx == 2'd1) begin
                rx_first <= 1'b1;
                len      <= {8'h00, rx_byte};
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= (in_hdr || cnt != len) ? ST_LOAD : ST_FINISH;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master with a mode-0 SPI slave model.
// Expected MOSI/rx bytes are queued at stimulus time and drained on output.
module tb_spi_cmd_master;

  localparam int CD  = 2;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b0;
  logic        irq_n = 1'b1;
  logic        cmd_start = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_len = 16'd0;
  logic        busy;
  logic        src_rd;
  logic [7:0]  src_data = 8'h00;
  logic        rx_en = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_first;
  logic        done;
  logic        cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] src_q[$];
  logic [7:0] miso_q[$];
  logic [8:0] rx_exp[$];
  logic [8:0] rx_obs[$];

  int done_cnt = 0;
  int src_cnt = 0;
  int err_cnt = 0;
  int rise_cnt = 0;
  int brise_cnt = 0;
  int bad_done = 0;
  int mon_n = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [7:0] s_byte = 8'hFF;
  logic sclk_q = 1'b0;
  logic busy_q = 1'b0;
  logic src_take = 1'b0;

  spi_cmd_master #(
    .CLK_DIV(CD),
    .GAP_CYCLES(GAP),
    .DUMMY_BYTE(8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .irq_n    (irq_n),
    .cmd_start(cmd_start),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .busy     (busy),
    .src_rd   (src_rd),
    .src_data (src_data),
    .rx_en    (rx_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (done && busy) bad_done++;
    if (src_rd) src_cnt++;
    if (cmd_err) err_cnt++;
    if (sclk && !sclk_q) rise_cnt++;
    if (busy && !busy_q) brise_cnt++;
    if (rx_valid) rx_obs.push_back({rx_first, rx_data});
    sclk_q = sclk;
    busy_q = busy;
  end

  always @(posedge sclk or posedge reset) begin
    if (reset) begin
      mon_n = 0;
    end else begin
      mon_sh = {mon_sh[6:0], mosi};
      mon_n++;
      if (mon_n == 8) begin
        obs_q.push_back(mon_sh);
        mon_n = 0;
      end
    end
  end

  always @(negedge sclk) begin
    if (mon_n == 0) begin
      if (miso_q.size() > 0) s_byte = miso_q.pop_front();
      else s_byte = 8'hFF;
    end else begin
      s_byte = {s_byte[6:0], 1'b0};
    end
    miso = s_byte[7];
  end

  always @(negedge clk) src_take = src_rd;

  always @(posedge clk) begin
    if (src_take && src_q.size() > 0) void'(src_q.pop_front());
    src_data <= (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] len);
    @(negedge clk);
    cmd_op = op;
    cmd_len = len;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sclk, mosi, busy, src_rd, rx_valid, rx_first, done, cmd_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outs got %b want 00000000",
        {sclk, mosi, busy, src_rd, rx_valid, rx_first, done, cmd_err});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_send();
    int d0, s0, b0, lat;
    logic [7:0] e, o;
    d0 = done_cnt;
    s0 = src_cnt;
    b0 = bad_done;
    src_q = '{8'hA1, 8'hB2, 8'hC3};
    exp_q = '{8'h66, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    obs_q.delete();
    repeat (2) @(negedge clk);
    cmd_op = 2'b01;
    cmd_len = 16'd3;
    cmd_start = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL send_busy got %b want 1", busy);
    end
    lat = 0;
    while (sclk !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != CD + 1) begin
      n_bad++;
      $display("FAIL send_latency got %0d want %0d", lat, CD + 1);
    end
    wait_done(d0 + 1, 2000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL send_mosi got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL send_mosi got %h want %h", o, e);
        end
      end
    end
    n_cmp++;
    if (src_cnt - s0 != 3) begin
      n_bad++;
      $display("FAIL send_src_rd got %0d want 3", src_cnt - s0);
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL send_done got %0d want 1", done_cnt - d0);
    end
    n_cmp++;
    if (bad_done != b0) begin
      n_bad++;
      $display("FAIL send_busy_at_done got %0d want 0", bad_done - b0);
    end
  endtask

  task automatic test_config();
    int d0, s0;
    logic [7:0] e, o, p;
    d0 = done_cnt;
    s0 = src_cnt;
    obs_q.delete();
    exp_q = '{8'h11, 8'h01, 8'h02};
    for (int i = 0; i < 258; i++) begin
      p = 8'((i * 37 + 5) & 255);
      src_q.push_back(p);
      exp_q.push_back(p);
    end
    repeat (2) @(negedge clk);
    issue(2'b10, 16'h0102);
    wait_done(d0 + 1, 20000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL cfg_mosi got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL cfg_mosi got %h want %h", o, e);
        end
      end
    end
    n_cmp++;
    if (src_cnt - s0 != 258) begin
      n_bad++;
      $display("FAIL cfg_src_rd got %0d want 258", src_cnt - s0);
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL cfg_done got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_fetch();
    int d0, b0;
    logic [7:0] e, o;
    logic [8:0] re, ro;
    d0 = done_cnt;
    rx_en = 1'b1;
    miso_q = '{8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    s_byte = 8'hEE;
    miso = 1'b1;
    exp_q = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rx_exp = '{9'h104, 9'h010, 9'h020, 9'h030, 9'h040};
    obs_q.delete();
    rx_obs.delete();
    @(negedge clk);
    irq_n = 1'b0;
    wait_done(d0 + 1, 5000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL fetch_mosi got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL fetch_mosi got %h want %h", o, e);
        end
      end
    end
    while (rx_exp.size() > 0) begin
      re = rx_exp.pop_front();
      n_cmp++;
      if (rx_obs.size() == 0) begin
        n_bad++;
        $display("FAIL fetch_rx got none want %h", re);
      end else begin
        ro = rx_obs.pop_front();
        if (ro !== re) begin
          n_bad++;
          $display("FAIL fetch_rx got %h want %h", ro, re);
        end
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL fetch_done got %0d want 1", done_cnt - d0);
    end
    b0 = brise_cnt;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (brise_cnt != b0) begin
      n_bad++;
      $display("FAIL fetch_rearm got %0d starts want 0", brise_cnt - b0);
    end
    irq_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_priority();
    int d0;
    logic [7:0] e, o;
    logic [8:0] ro;
    d0 = done_cnt;
    rx_en = 1'b1;
    src_q = '{8'h5A};
    miso_q = '{8'hEE, 8'hEE, 8'hEE, 8'h00};
    s_byte = 8'hEE;
    miso = 1'b1;
    exp_q = '{8'h66, 8'h01, 8'h5A, 8'h77, 8'h00};
    obs_q.delete();
    rx_obs.delete();
    repeat (2) @(negedge clk);
    cmd_op = 2'b01;
    cmd_len = 16'd1;
    cmd_start = 1'b1;
    irq_n = 1'b0;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_done(d0 + 2, 6000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL prio_mosi got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL prio_mosi got %h want %h", o, e);
        end
      end
    end
    n_cmp++;
    ro = (rx_obs.size() > 0) ? rx_obs[0] : 9'h1FF;
    if (rx_obs.size() != 1 || ro !== 9'h100) begin
      n_bad++;
      $display("FAIL prio_rx got %0d items first %h want 1 item 100",
        rx_obs.size(), ro);
    end
    n_cmp++;
    if (done_cnt - d0 != 2) begin
      n_bad++;
      $display("FAIL prio_done got %0d want 2", done_cnt - d0);
    end
    irq_n = 1'b1;
    rx_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reject();
    int e0, r0, b0, d0;
    logic [7:0] e, o;
    e0 = err_cnt;
    r0 = rise_cnt;
    b0 = brise_cnt;
    issue(2'b01, 16'd0);
    issue(2'b01, 16'd300);
    issue(2'b00, 16'd5);
    issue(2'b11, 16'd5);
    issue(2'b10, 16'd0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 != 5) begin
      n_bad++;
      $display("FAIL reject_err got %0d want 5", err_cnt - e0);
    end
    n_cmp++;
    if (rise_cnt != r0 || brise_cnt != b0) begin
      n_bad++;
      $display("FAIL reject_idle got %0d rises %0d starts want 0 0",
        rise_cnt - r0, brise_cnt - b0);
    end
    d0 = done_cnt;
    src_q = '{8'h11, 8'h22};
    exp_q = '{8'h66, 8'h02, 8'h11, 8'h22};
    obs_q.delete();
    repeat (2) @(negedge clk);
    issue(2'b01, 16'd2);
    repeat (60) @(negedge clk);
    issue(2'b10, 16'd5);
    wait_done(d0 + 1, 3000);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 != 5) begin
      n_bad++;
      $display("FAIL busy_ignore_err got %0d want 5", err_cnt - e0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL busy_ignore_mosi got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL busy_ignore_mosi got %h want %h", o, e);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0 || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL busy_ignore_extra got %0d bytes %0d done want 0 1",
        obs_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit found;
    logic [7:0] e, o;
    src_q = '{8'hAA, 8'hBB, 8'hCC};
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    issue(2'b01, 16'd3);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (obs_q.size() >= 1 && sclk === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reset_mid_reach got 0 want 1");
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (sclk !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_sclk got %b want 0", sclk);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_busy got %b want 0", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    src_q.delete();
    obs_q.delete();
    rx_obs.delete();
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    src_q = '{8'h3C};
    exp_q = '{8'h66, 8'h01, 8'h3C};
    repeat (2) @(negedge clk);
    issue(2'b01, 16'd1);
    wait_done(d0 + 1, 2000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL after_reset_mosi got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL after_reset_mosi got %h want %h", o, e);
        end
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL after_reset_done got %0d want 1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_send();
    test_config();
    test_fetch();
    test_priority();
    test_reject();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

Host-side initiator for the FPGA's SPI command protocol. It drives SCLK/MOSI and samples MISO against the FPGA SPI slave controller, issuing the three command frames: send packet (0x66), fetch packet (0x77) and write config (0x11). Fetches are triggered by the slave's active-low receive interrupt. The block sits in a host/bridge FPGA or a loop-back test build, between local byte streams and the SPI pins.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (≥2).
- GAP_CYCLES, 16: idle clk cycles between bytes, giving the slave time to reload its TX byte.
- DUMMY_BYTE, 8'h00: MOSI filler while reading.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sclk  out  1  SPI clock; idles low
- mosi  out  1  SPI data out, MSB first
- miso  in  1  SPI data in
- irq_n  in  1  slave receive interrupt, active low, asynchronous
- cmd_start  in  1  one-cycle request; sampled only when !busy
- cmd_op  in  2  operation: 2'b01 send packet, 2'b10 write config
- cmd_len  in  16  payload byte count
- busy  out  1  high from an accepted command/fetch until done
- src_rd  out  1  one-cycle pop of the payload source; src_data is show-ahead and is consumed in this cycle
- src_data  in  8  payload byte
- rx_en  in  1  enables interrupt-driven fetches
- rx_data  out  8  received byte
- rx_valid  out  1  one-cycle strobe for rx_data
- rx_first  out  1  with rx_valid, marks the length byte
- done  out  1  one-cycle end-of-operation pulse
- cmd_err  out  1  one-cycle pulse for a rejected command

## Operation
- Reset values: sclk=0, mosi=0, busy=0, src_rd=0, rx_valid=0, rx_first=0, rx_data=0, done=0, cmd_err=0. The FSM resets to IDLE and rx_armed resets to 1.
- irq_n passes through a 2-flop synchronizer to give irq_s.
- IDLE arbitration applies in one cycle, highest priority first:
  - cmd_start: accepted.
  - Otherwise, if rx_en && !irq_s && rx_armed, a fetch starts.
- A rejected command pulses cmd_err and leaves busy low. Rejection cases:
  - Send packet with cmd_len==0 or cmd_len>255.
  - Config with cmd_len==0.
  - cmd_op of 00 or 11.
- Send packet: bytes 0x66, cmd_len[7:0], then cmd_len payload bytes. Each payload byte is taken with src_rd in the cycle its transfer loads.
- Write config: bytes 0x11, cmd_len[15:8], cmd_len[7:0], then cmd_len payload bytes.
- Fetch:
  - Send 0x77; MISO for that byte is discarded. Clear rx_armed.
  - Clock DUMMY_BYTE. The returned byte is L, emitted with rx_valid and rx_first.
  - Clock L more dummy bytes, emitting each with rx_valid.
  - If L==0, end right after the length byte.
- rx_armed sets again when irq_s is seen high. This blocks a second fetch on the stale low interrupt.
- Every operation ends with done=1 for one cycle, followed by busy=0 in the same cycle.
- FSM states:
  - IDLE → LOAD → SHIFT → GAP → (LOAD | FINISH) → IDLE.
  - Separate phase counters track header index and payload count.
- Payload count is 16-bit. The FSM reaches FINISH when count==len, with no wrap.

## Timing
- Byte frame, SPI mode 0:
  - At LOAD, mosi = bit7.
  - After CLK_DIV cycles sclk rises, and miso is sampled in that cycle.
  - After another CLK_DIV cycles sclk falls and mosi shifts.
  - After 8 bits, sclk is low and the byte is complete: 16·CLK_DIV cycles.
- Then GAP_CYCLES idle cycles before the next LOAD. Per byte: 16·CLK_DIV+GAP_CYCLES cycles.
- rx_valid asserts the cycle after the 8th falling edge.
- done asserts the cycle after the last GAP ends.
- Accept-to-first-SCLK-rise latency is 1+CLK_DIV cycles.
- irq_n-to-fetch latency is 3 cycles (2 sync + arbitration) when idle.
- A cmd_start arriving while busy is ignored: no cmd_err, no queuing.
- Reset mid-byte: sclk drops low asynchronously and the frame is abandoned. The slave resynchronizes on the next command byte.

## Structure
- Shared package spi_cmd_pkg holds:
  - Opcode constants OPC_SEND=8'h66, OPC_FETCH=8'h77, OPC_CFG=8'h11.
  - cmd_op encodings.
  - The FSM state enum.
- One sub-module, spi_master_byte, is the byte shifter:
  - Inputs: load, tx byte.
  - Outputs: sclk, mosi, rx byte, byte_done.
  - Parameterized by CLK_DIV.
  - The top level keeps the frame FSM, gap counter, arbitration and irq synchronizer.

## Test plan
- Send packet with cmd_len=3 and source bytes A1,B2,C3 → MOSI carries 66,03,A1,B2,C3. There are 3 src_rd pulses and one done; busy falls with done.
- Config with cmd_len=0x0102 → MOSI carries 11,01,02 followed by 258 payload bytes, then done.
- With rx_en=1, drive irq_n low and a slave model returning xx,04,10,20,30,40 → MOSI carries 77 then five 00 bytes. The bench sees rx_valid ×5, with rx_first on 04, then done. No second fetch occurs until irq_n has gone high.
- Assert cmd_start with op=01 in the same cycle irq_n falls → the send runs first and the fetch follows immediately after its done.
- Send packet with cmd_len=0, then cmd_len=300 → two cmd_err pulses and no SCLK activity. A cmd_start during an active send is ignored.
- Assert reset during byte 2 of a send → sclk=0 and busy=0 immediately. A subsequent send completes normally.
